// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, round constants and GF(2^8) helpers
package aes_pkg;
  localparam int NUM_ROUNDS_AES128 = 10;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef enum logic {IDLE, ROUND} aes_fsm_t;
  typedef logic [127:0] aes_block_t;
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box from first principles: inverse as a^254, then the FIPS affine map
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/add_round_key.sv
// add_round_key: XOR state with the round key
module add_round_key
  import aes_pkg::*;
(
  input  aes_block_t state_i,
  input  aes_block_t key_i,
  output aes_block_t state_o
);
  assign state_o = state_i ^ key_i;
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte AES substitution
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = sbox_f(a_i);
endmodule

// File: rtl/key_step.sv
// key_step: derives the next AES-128 round key from the current one
module key_step
  import aes_pkg::*;
(
  input  aes_block_t rk_i,
  input  logic [7:0] rcon_i,
  output aes_block_t rk_o
);
  logic [31:0] w0, w1, w2, w3, rot, sub;
  assign {w0, w1, w2, w3} = rk_i;
  assign rot = {w3[23:0], w3[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sw
    aes_sbox u_sbox (.a_i(rot[31-8*i -: 8]), .y_o(sub[31-8*i -: 8]));
  end
  assign rk_o[127:96] = w0 ^ sub ^ {rcon_i, 24'h0};
  assign rk_o[95:64]  = w1 ^ rk_o[127:96];
  assign rk_o[63:32]  = w2 ^ rk_o[95:64];
  assign rk_o[31:0]   = w3 ^ rk_o[63:32];
endmodule

// File: rtl/mix_columns.sv
// mix_columns: column mix, bypassed when en_i is low (final round)
module mix_columns
  import aes_pkg::*;
(
  input  aes_block_t state_i,
  input  logic       en_i,
  output aes_block_t state_o
);
  aes_block_t mixed;
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_i[127-32*c -: 8];
    assign a1 = state_i[119-32*c -: 8];
    assign a2 = state_i[111-32*c -: 8];
    assign a3 = state_i[103-32*c -: 8];
    assign mixed[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end
  assign state_o = en_i ? mixed : state_i;
endmodule

// File: rtl/shift_rows.sv
// shift_rows: row r rotated left by r bytes; byte index is 4*col+row
module shift_rows
  import aes_pkg::*;
(
  input  aes_block_t state_i,
  output aes_block_t state_o
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign state_o[127-8*(4*c+r) -: 8] = state_i[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: S-box applied to all sixteen state bytes
module sub_bytes
  import aes_pkg::*;
(
  input  aes_block_t state_i,
  output aes_block_t state_o
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sbox (.a_i(state_i[127-8*i -: 8]), .y_o(state_o[127-8*i -: 8]));
  end
endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES-128 encryptor, one round per clock
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] cyphertext
);
  localparam int RW = $clog2(NUM_ROUNDS + 1);
  aes_fsm_t      fsm_q, fsm_d;
  aes_block_t    state_q, state_d, rk_q, rk_d, ct_q, ct_d;
  aes_block_t    sb, sr, mc, ark, rk_next;
  logic [RW-1:0] round_q, round_d;
  logic          busy_q, busy_d, done_q, done_d, last;
  assign last = round_q == RW'(NUM_ROUNDS);
  key_step      u_ks  (.rk_i(rk_q), .rcon_i(rcon_of(4'(round_q))), .rk_o(rk_next));
  sub_bytes     u_sb  (.state_i(state_q), .state_o(sb));
  shift_rows    u_sr  (.state_i(sb), .state_o(sr));
  mix_columns   u_mc  (.state_i(sr), .en_i(!last), .state_o(mc));
  add_round_key u_ark (.state_i(mc), .key_i(rk_next), .state_o(ark));
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rk_d    = rk_q;
    round_d = round_q;
    ct_d    = ct_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (fsm_q == IDLE) begin
      if (start) begin
        state_d = plaintext ^ key;
        rk_d    = key;
        round_d = RW'(1);
        fsm_d   = ROUND;
        busy_d  = 1'b1;
      end
    end else begin
      state_d = ark;
      rk_d    = rk_next;
      round_d = last ? '0 : round_q + 1'b1;
      ct_d    = last ? ark : ct_q;
      done_d  = last;
      busy_d  = !last;
      fsm_d   = last ? IDLE : ROUND;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      round_q <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      ct_q    <= ct_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign cyphertext = ct_q;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: FIPS-197 vectors plus random blocks against a table-driven AES model
module tb_aes_round_engine;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, busy, done;
  logic [127:0] key = '0, plaintext = '0, cyphertext;
  int errors = 0, checks = 0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_round_engine dut (.clk(clk), .reset(reset), .start(start), .key(key),
                        .plaintext(plaintext), .busy(busy), .done(done), .cyphertext(cyphertext));

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX_T[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] p, input int upto);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] coef [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [127:0] rk, out;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= upto; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sb(s[4*((c+r)%4)+r]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          s[4*c+r] = 8'h00;
          for (int j = 0; j < 4; j++)
            s[4*c+r] = s[4*c+r] ^ (rnd == 10 ? (j == r ? t[4*c+j] : 8'h00) : gm(t[4*c+j], coef[(j-r+4)%4]));
        end
      rk = expand(k, rnd);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [127:0] k, input logic [127:0] p, input logic [127:0] exp, input int poke);
    int n = 0, bc;
    bit got = 1'b0;
    key = k; plaintext = p; start = 1'b1;
    tick();
    start = 1'b0;
    bc = int'(busy);
    while (n < 30 && !got) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      start = (n == poke);
      tick();
      n++;
      if (n == 1) check("round1_state", dut.state_q, enc(k, p, 1));
      if (done) got = 1'b1;
      else bc += int'(busy);
    end
    start = 1'b0;
    check("latency", 128'(n), 128'(10));
    check("busy_cycles", 128'(bc), 128'(10));
    check("cyphertext", cyphertext, exp);
    check("round10_key", dut.rk_q, expand(k, 10));
    tick();
    check("done_pulse", 128'(done), 128'(0));
    check("idle_after", 128'(busy), 128'(0));
  endtask

  initial begin
    logic [127:0] rk, rp;
    int t1;
    bit seen, held;
    tick(); tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_ct", cyphertext, 128'(0));
    reset = 1'b0;
    tick();
    // FIPS-197 App. B and C.1
    run(K1, P1, C1, -1);
    check("fips_rk10", dut.rk_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    key = K1; plaintext = P1; start = 1'b1;
    tick(); tick();
    check("fips_round1", dut.state_q, 128'ha49c7ff2689f352b6b5bea43026a5049);
    start = 1'b0;
    repeat (12) tick();
    run(K3, P3, C3, -1);
    // back-to-back with start held high; inputs swapped while busy
    key = K1; plaintext = P1; start = 1'b1;
    tick();
    key = K3; plaintext = P3;
    t1 = 0;
    while (t1 < 30 && !done) begin tick(); t1++; end
    check("b2b_first_lat", 128'(t1), 128'(10));
    check("b2b_first_ct", cyphertext, C1);
    t1 = 0; held = 1'b1;
    do begin
      tick(); t1++;
      if (!done && cyphertext !== C1) held = 1'b0;
    end while (t1 < 30 && !done);
    start = 1'b0;
    check("b2b_gap", 128'(t1), 128'(11));
    check("b2b_hold", 128'(held), 128'(1));
    check("b2b_second_ct", cyphertext, C3);
    tick();
    check("b2b_stop", 128'(busy), 128'(0));
    // abort mid-operation
    key = K1; plaintext = P1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    check("abort_ct", cyphertext, 128'(0));
    seen = 1'b0;
    repeat (15) begin tick(); if (done || busy) seen = 1'b1; end
    check("abort_quiet", 128'(seen), 128'(0));
    run(K1, P1, C1, -1);
    // start while busy is ignored
    run(K3, P3, C3, 2);
    for (int i = 0; i < 8; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      run(rk, rp, enc(rk, rp, 10), int'($urandom_range(0, 9)) - 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
Iterative AES-128 encryption engine built around the existing per-round combinational stages: sub_bytes, shift_rows, mix_columns and add_round_key. It holds the 128-bit cipher state and current round key in registers and runs one full round per clock. It drives the mix_columns enable, which is low in the final round, and consumes the mix_columns output through add_round_key. Round keys are generated on the fly by a key-schedule step, so there is no key RAM.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported, and the value also sets the round counter width.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request encryption; sampled only in IDLE
key  input  128  cipher key; byte 0 = key[127:120]
plaintext  input  128  input block; column-major, column 0 = [127:96], s[0][0] = [127:120]
busy  output  1  high while an encryption is in progress
done  output  1  one-cycle pulse when cyphertext is updated
cyphertext  output  128  result; held stable until the next completion

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. It is sampled on the rising edge of clk and overrides every other input.
- Reset values:
  - All outputs: busy=0, done=0, cyphertext=0.
  - Internal: state_q=0, rk_q=0, round_q=0, fsm=IDLE.
- FSM states: IDLE, ROUND.
- IDLE:
  - On an edge with start=1: state_q <= plaintext ^ key (initial AddRoundKey); rk_q <= key; round_q <= 1; fsm <= ROUND; busy <= 1.
  - key and plaintext are captured at that edge only; later changes are ignored.
- ROUND, each edge:
  - rk_next = key_step(rk_q, rcon[round_q]).
  - state_q <= add_round_key(mix_columns(shift_rows(sub_bytes(state_q)), enable = (round_q != NUM_ROUNDS)), rk_next).
  - rk_q <= rk_next; round_q <= round_q + 1.
- Completion:
  - On the edge where round_q == NUM_ROUNDS: cyphertext <= the computed final state; done <= 1; busy <= 0; fsm <= IDLE; round_q <= 0.
  - done deasserts on the following edge.
- Latency: start is sampled at edge E0 and done/cyphertext become visible after edge E0+10. This is 11 clocks start-to-done, and busy is high for exactly 10 cycles.
- start while busy=1 is ignored, with no queuing.
- start=1 in the same cycle that done=1 (the engine is back in IDLE) is accepted: a back-to-back encryption begins and cyphertext holds the previous result until the new done.
- start held high continuously gives back-to-back encryptions, one every 11 cycles.
- Reset mid-operation aborts the encryption: all registers return to their reset values, no done pulse is produced, and cyphertext clears to 0.
- rcon for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36, placed in the top byte of the word.
- key_step:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon.
  - w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - w0 = rk[127:96].
- All arithmetic is XOR / GF(2^8); round_q is $clog2(NUM_ROUNDS+1) bits and never wraps past NUM_ROUNDS.

Decomposition:
- Package aes_pkg holds:
  - NUM_ROUNDS_AES128 = 10;
  - the rcon table as a constant array [1:10] of 8-bit values;
  - typedef enum logic {IDLE, ROUND} aes_fsm_t;
  - typedef logic [127:0] aes_block_t.
- Sub-module key_step: combinational next-round-key generation. It takes rk and rcon and produces rk_next, instantiating four sbox lookups for SubWord.
- The engine instantiates the existing sub_bytes, shift_rows, mix_columns and add_round_key blocks plus one key_step. It holds the registers and FSM only.

Test Plan:
1. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, pulse start -> after 11 clocks done=1 for one cycle, cyphertext=3925841d02dc09fbdc118597196a0b32, busy high for 10 cycles.
2. Same vector, internal probe -> state_q after round 1 = a49c7ff2689f352b6b5bea43026a5049; rk_q after round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
3. FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cyphertext=69c4e0d86a7b0430d8cdb78070b4c55a.
4. start held high with vector 1 then vector 3 applied back-to-back -> two done pulses 11 cycles apart. Changing key/plaintext while busy does not alter the results. cyphertext holds vector 1's result until the second done.
5. Assert reset for one cycle at round 5 -> busy=0, done never pulses, cyphertext=0. A subsequent start with vector 1 yields the correct result.
6. Pulse start while busy at round 3 -> ignored, with a single done at the original time and the correct result.
